// File: rtl/alu_pkg.sv
// Shared definitions for the RV32 ALU: default widths and the 3-bit operation encoding.
package alu_pkg;

  localparam int unsigned WIDTH      = 32;
  localparam int unsigned SHAMT_W    = 5;
  localparam int unsigned ALU_CTRL_W = 3;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR = 3'b100;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 3'b101;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL = 3'b110;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL = 3'b111;

endpackage

// File: rtl/rv_alu_comb.sv
// Purely combinational ALU datapath: one shared adder serves ADD, SUB and SLT.
module rv_alu_comb #(
  parameter int unsigned WIDTH   = alu_pkg::WIDTH,
  parameter int unsigned SHAMT_W = alu_pkg::SHAMT_W
) (
  input  logic [WIDTH-1:0]                 a,
  input  logic [WIDTH-1:0]                 b,
  input  logic [alu_pkg::ALU_CTRL_W-1:0]   alu_ctrl,
  output logic [WIDTH-1:0]                 result_c,
  output logic                             carry_c,
  output logic                             overflow_c
);
  import alu_pkg::*;

  localparam int unsigned SUM_W = WIDTH + 1;

  logic               w_sub;
  logic [WIDTH-1:0]   w_b_op;
  logic [SUM_W-1:0]   w_sum;
  logic               w_ovf;
  logic               w_lt;
  logic [SHAMT_W-1:0] w_shamt;

  // SUB and SLT both need a - b = a + ~b + 1
  assign w_sub   = (alu_ctrl == ALU_SUB) || (alu_ctrl == ALU_SLT);
  assign w_b_op  = w_sub ? ~b : b;
  assign w_sum   = {1'b0, a} + {1'b0, w_b_op} + SUM_W'(w_sub);
  assign w_ovf   = (a[WIDTH-1] == w_b_op[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
  assign w_lt    = w_sum[WIDTH-1] ^ w_ovf;
  assign w_shamt = b[SHAMT_W-1:0];

  always_comb begin
    result_c   = '0;
    carry_c    = 1'b0;
    overflow_c = 1'b0;
    case (alu_ctrl)
      ALU_ADD, ALU_SUB: begin
        result_c   = w_sum[WIDTH-1:0];
        carry_c    = w_sum[WIDTH];
        overflow_c = w_ovf;
      end
      ALU_AND: result_c = a & b;
      ALU_OR:  result_c = a | b;
      ALU_XOR: result_c = a ^ b;
      ALU_SLT: result_c = WIDTH'(w_lt);
      ALU_SLL: result_c = a << w_shamt;
      ALU_SRL: result_c = a >> w_shamt;
      default: result_c = '0;
    endcase
  end

endmodule

// File: rtl/rv_alu.sv
// Registered RV32 ALU: one-cycle latency result with zero/negative/carry/overflow and valid strobe.
module rv_alu #(
  parameter int unsigned WIDTH   = alu_pkg::WIDTH,
  parameter int unsigned SHAMT_W = alu_pkg::SHAMT_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [WIDTH-1:0]               a,
  input  logic [WIDTH-1:0]               b,
  input  logic [alu_pkg::ALU_CTRL_W-1:0] alu_ctrl,
  output logic [WIDTH-1:0]               result,
  output logic                           zero,
  output logic                           negative,
  output logic                           carry,
  output logic                           overflow,
  output logic                           out_valid
);

  logic [WIDTH-1:0] w_result;
  logic             w_carry;
  logic             w_overflow;

  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_negative;
  logic             r_carry;
  logic             r_overflow;
  logic             r_out_valid;

  rv_alu_comb #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_comb (
    .a          (a),
    .b          (b),
    .alu_ctrl   (alu_ctrl),
    .result_c   (w_result),
    .carry_c    (w_carry),
    .overflow_c (w_overflow)
  );

  // Capture only on in_valid so don't-care operands never reach the outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result    <= '0;
      r_zero      <= 1'b1;
      r_negative  <= 1'b0;
      r_carry     <= 1'b0;
      r_overflow  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_result   <= w_result;
        r_zero     <= (w_result == '0);
        r_negative <= w_result[WIDTH-1];
        r_carry    <= w_carry;
        r_overflow <= w_overflow;
      end
    end
  end

  assign result    = r_result;
  assign zero      = r_zero;
  assign negative  = r_negative;
  assign carry     = r_carry;
  assign overflow  = r_overflow;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_rv_alu.sv
// Directed self-checking bench for rv_alu: each task drives its own vectors and compares inline.
module tb_rv_alu;
  import alu_pkg::*;

  localparam int unsigned W = 32;

  logic         clk    = 1'b0;
  logic         clk_en = 1'b1;
  logic         rst    = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   alu_ctrl = 3'b000;
  logic [W-1:0] result;
  logic         zero, negative, carry, overflow, out_valid;

  int n_vec = 0;
  int n_err = 0;

  rv_alu #(.WIDTH(W), .SHAMT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .alu_ctrl  (alu_ctrl),
    .result    (result),
    .zero      (zero),
    .negative  (negative),
    .carry     (carry),
    .overflow  (overflow),
    .out_valid (out_valid)
  );

  // Gated clock so reset can be exercised with the clock stopped
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // Present one cycle of stimulus and return 1 time unit after the sampling edge
  task automatic step(input logic v, input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    in_valid = v;
    alu_ctrl = op;
    a        = x;
    b        = y;
    @(posedge clk);
    #1;
  endtask

  // Observed vector order: {result, zero, negative, carry, overflow, out_valid}
  task automatic test_reset();
    step(1'b1, ALU_ADD, 32'd7, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    clk_en = 1'b0;
    #3 rst = 1'b1;
    #1;
    n_vec++;
    if ({result, zero, negative, carry, overflow, out_valid} !== {32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_async got %h/%b%b%b%b%b want 00000000/10000",
               result, zero, negative, carry, overflow, out_valid);
    end
    #3 rst = 1'b0;
    clk_en = 1'b1;
    step(1'b1, ALU_ADD, 32'd0, 32'd5);
    n_vec++;
    if ({result, zero, negative, carry, overflow, out_valid} !== {32'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_first_add got %h/%b%b%b%b%b want 00000005/00001",
               result, zero, negative, carry, overflow, out_valid);
    end
  endtask

  task automatic test_sub();
    logic [W-1:0] va [3] = '{32'd0, 32'd20, 32'd20};
    logic [W-1:0] vb [3] = '{32'd5, 32'd20, 32'd10};
    logic [W+4:0] ex [3] = '{{32'hFFFF_FFFB, 5'b01001},
                             {32'h0000_0000, 5'b10101},
                             {32'h0000_000A, 5'b00101}};
    for (int i = 0; i < 3; i++) begin
      step(1'b1, ALU_SUB, va[i], vb[i]);
      n_vec++;
      if ({result, zero, negative, carry, overflow, out_valid} !== ex[i]) begin
        n_err++;
        $display("FAIL sub[%0d] got %h want %h", i,
                 {result, zero, negative, carry, overflow, out_valid}, ex[i]);
      end
    end
  endtask

  task automatic test_logic();
    logic [2:0]   op [3] = '{ALU_AND, ALU_OR, ALU_XOR};
    logic [W-1:0] va [3] = '{32'd0, 32'd0, 32'hF0F0_F0F0};
    logic [W-1:0] vb [3] = '{32'd5, 32'd5, 32'hFFFF_0000};
    logic [W+4:0] ex [3] = '{{32'h0000_0000, 5'b10001},
                             {32'h0000_0005, 5'b00001},
                             {32'h0F0F_F0F0, 5'b00001}};
    for (int i = 0; i < 3; i++) begin
      step(1'b1, op[i], va[i], vb[i]);
      n_vec++;
      if ({result, zero, negative, carry, overflow, out_valid} !== ex[i]) begin
        n_err++;
        $display("FAIL logic[%0d] got %h want %h", i,
                 {result, zero, negative, carry, overflow, out_valid}, ex[i]);
      end
    end
  endtask

  task automatic test_slt();
    logic [W-1:0] va [4] = '{32'd5,  32'd10, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    logic [W-1:0] vb [4] = '{32'd10, 32'd5,  32'd1,         32'h8000_0000};
    logic [W+4:0] ex [4] = '{{32'd1, 5'b00001},
                             {32'd0, 5'b10001},
                             {32'd1, 5'b00001},
                             {32'd0, 5'b10001}};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, ALU_SLT, va[i], vb[i]);
      n_vec++;
      if ({result, zero, negative, carry, overflow, out_valid} !== ex[i]) begin
        n_err++;
        $display("FAIL slt[%0d] got %h want %h", i,
                 {result, zero, negative, carry, overflow, out_valid}, ex[i]);
      end
    end
  endtask

  task automatic test_flags_shift();
    logic [2:0]   op [4] = '{ALU_ADD, ALU_ADD, ALU_SLL, ALU_SRL};
    logic [W-1:0] va [4] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'h8000_0000};
    logic [W-1:0] vb [4] = '{32'd1, 32'd1, 32'h21, 32'd31};
    logic [W+4:0] ex [4] = '{{32'h8000_0000, 5'b01011},
                             {32'h0000_0000, 5'b10101},
                             {32'h0000_0002, 5'b00001},
                             {32'h0000_0001, 5'b00001}};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, op[i], va[i], vb[i]);
      n_vec++;
      if ({result, zero, negative, carry, overflow, out_valid} !== ex[i]) begin
        n_err++;
        $display("FAIL flags_shift[%0d] got %h want %h", i,
                 {result, zero, negative, carry, overflow, out_valid}, ex[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]   op [3] = '{ALU_ADD, ALU_SUB, ALU_XOR};
    logic [W+4:0] ex [3] = '{{32'h0000_0007, 5'b00001},
                             {32'hFFFF_FFFF, 5'b01001},
                             {32'h0000_0007, 5'b00001}};
    for (int i = 0; i < 3; i++) begin
      step(1'b1, op[i], 32'd3, 32'd4);
      n_vec++;
      if ({result, zero, negative, carry, overflow, out_valid} !== ex[i]) begin
        n_err++;
        $display("FAIL b2b[%0d] got %h want %h", i,
                 {result, zero, negative, carry, overflow, out_valid}, ex[i]);
      end
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 3'bxxx, 'x, 'x);
      n_vec++;
      if ({result, zero, negative, carry, overflow, out_valid} !== {32'h0000_0007, 5'b00000}) begin
        n_err++;
        $display("FAIL hold[%0d] got %h want %h", i,
                 {result, zero, negative, carry, overflow, out_valid}, {32'h0000_0007, 5'b00000});
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, ALU_ADD, 32'd1, 32'd1);
    in_valid = 1'b1;
    alu_ctrl = ALU_ADD;
    a        = 32'd5;
    b        = 32'd5;
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({result, zero, negative, carry, overflow, out_valid} !== {32'd0, 5'b10000}) begin
      n_err++;
      $display("FAIL reset_mid_clear got %h want %h",
               {result, zero, negative, carry, overflow, out_valid}, {32'd0, 5'b10000});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    step(1'b0, ALU_ADD, 32'd5, 32'd5);
    n_vec++;
    if ({result, zero, negative, carry, overflow, out_valid} !== {32'd0, 5'b10000}) begin
      n_err++;
      $display("FAIL reset_mid_discard got %h want %h",
               {result, zero, negative, carry, overflow, out_valid}, {32'd0, 5'b10000});
    end
    step(1'b1, ALU_ADD, 32'd9, 32'd0);
    n_vec++;
    if ({result, zero, negative, carry, overflow, out_valid} !== {32'd9, 5'b00001}) begin
      n_err++;
      $display("FAIL reset_mid_first got %h want %h",
               {result, zero, negative, carry, overflow, out_valid}, {32'd9, 5'b00001});
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_sub();
    test_logic();
    test_slt();
    test_flags_shift();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time bound so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/rv_alu.md
Name: rv_alu

Overview:
- 32-bit integer ALU for the single-cycle RISC-V datapath; executes the operation selected by the 3-bit ALU control from the main/ALU decoder.
- Feeds the register-file writeback mux (result) and the branch logic (zero, for BEQ/BNE).
- The combinational result is captured in an output register: one-cycle latency, with a valid strobe and status flags.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SHAMT_W, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  input  1  system clock; rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and control are valid this cycle.
- a  input  WIDTH  operand A (rs1).
- b  input  WIDTH  operand B (rs2 or immediate).
- alu_ctrl  input  3  operation select.
- result  output  WIDTH  registered operation result.
- zero  output  1  registered; 1 when result == 0.
- negative  output  1  registered; equals result[WIDTH-1].
- carry  output  1  registered; carry-out for ADD, NOT borrow for SUB, 0 for all other operations.
- overflow  output  1  registered; signed overflow for ADD/SUB, 0 for all other operations.
- out_valid  output  1  registered copy of in_valid.

Behaviour:
- alu_ctrl encoding:
  - 000 ADD: a+b
  - 001 SUB: a-b
  - 010 AND: a&b
  - 011 OR: a|b
  - 100 XOR: a^b
  - 101 SLT: signed a<b, result 1 or 0, zero-extended
  - 110 SLL: a << b[SHAMT_W-1:0]
  - 111 SRL: logical a >> b[SHAMT_W-1:0]
- Arithmetic wraps modulo 2^WIDTH; no saturation.
- SUB is computed as a + ~b + 1 using the same adder as ADD.
- SLT is derived from the subtractor: sign(a-b) XOR overflow.
- Shift ignores b bits above SHAMT_W-1.
- ADD overflow: operands have equal sign and the result sign differs.
- SUB overflow: operands have different signs and the result sign differs from a.
- Latency: inputs are sampled on the rising edge of clk when in_valid=1. result and flags update on that edge and are visible one cycle after presentation. out_valid=1 in that same cycle.
- in_valid=0: result and flags hold their previous values; out_valid=0 on the next edge.
- Back-to-back in_valid: one result per cycle; no stalls; no backpressure.
- Reset (async, takes effect immediately, independent of clk):
  - result=0, zero=1, negative=0, carry=0, overflow=0, out_valid=0.
- Reset asserted mid-operation discards the in-flight computation. The first valid output after rst deasserts comes from the first in_valid sampled after that deassertion.
- Flags always correspond to the same operation as result; never mixed across cycles.
- alu_ctrl, a and b are don't-care when in_valid=0. X on those inputs must not propagate into outputs when in_valid=0.

Decomposition:
- Shared package alu_pkg:
  - ALU op localparams ALU_ADD..ALU_SRL, with the 3-bit encoding above.
  - WIDTH default.
- One natural sub-module: rv_alu_comb, a purely combinational datapath (a, b, alu_ctrl -> result, carry, overflow).
- The top-level rv_alu adds the output register, zero/negative derivation and valid tracking.

Test Plan:
- Reset: assert rst with clk stopped -> outputs immediately result=0, zero=1, out_valid=0. Deassert, then ADD a=0, b=5 -> next cycle result=5, zero=0, out_valid=1.
- SUB/branch:
  - a=0, b=5 -> result=0xFFFFFFFB, negative=1, carry=0.
  - a=20, b=20 -> result=0, zero=1.
  - a=20, b=10 -> result=10, zero=0.
- Logic:
  - AND a=0, b=5 -> result=0, zero=1.
  - OR a=0, b=5 -> result=5.
  - XOR a=0xF0F0F0F0, b=0xFFFF0000 -> 0x0F0FF0F0.
- SLT:
  - a=5, b=10 -> 1.
  - a=10, b=5 -> 0.
  - a=0xFFFFFFFF (-1), b=1 -> 1.
  - a=0x7FFFFFFF, b=0x80000000 -> 0 (overflow case).
- Overflow and carry:
  - ADD 0x7FFFFFFF+1 -> 0x80000000, overflow=1.
  - ADD 0xFFFFFFFF+1 -> 0, carry=1, zero=1.
  - SLL a=1, b=0x21 -> 2 (only b[4:0] used).
  - SRL a=0x80000000, b=31 -> 1.
- Hold/pipeline/reset:
  - Three back-to-back ops -> three consecutive correct results.
  - in_valid=0 gap -> outputs hold, out_valid=0.
  - rst pulse between edges -> outputs clear asynchronously.
